// File: rtl/prince_iter_engine.sv
// Iterative PRINCE cipher engine: 64-bit block, 128-bit key, encrypt/decrypt.
// Evaluates UNROLL of the 12 schedule slots per clock; handshakes on both sides.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   in_valid/in_ready request handshake; mode (0 enc, 1 dec), data_in, key sampled on accept
//   out_valid/out_ready result handshake; data_out registered, held until transfer
module prince_iter_engine #(
  parameter int unsigned UNROLL = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         mode,
  input  logic [63:0]  data_in,
  input  logic [127:0] key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [63:0]  data_out
);

  if (!(UNROLL == 1 || UNROLL == 2 || UNROLL == 3 || UNROLL == 4 || UNROLL == 6 ||
        UNROLL == 12)) begin : gen_bad_unroll
    $error("prince_iter_engine: UNROLL must be one of 1, 2, 3, 4, 6, 12");
  end

  localparam logic [63:0]  Alpha   = 64'hc0ac29b7c97c50dd;
  localparam logic [3:0]   Step    = 4'(UNROLL);
  // Nibble tables, entry i at bits [4*i +: 4].
  localparam logic [63:0]  Sbox    = 64'h4d5e087619ca23fb;
  localparam logic [63:0]  SboxInv = 64'h1ce5046a98df237b;
  // M' 16x16 blocks: entry i (bits [16*i +: 16]) is the image of input bit i.
  localparam logic [255:0] MatHat0 =
    256'h0888_4044_2202_1110_8880_0444_2022_1101_8808_4440_0222_1011_8088_4404_2220_0111;
  localparam logic [255:0] MatHat1 =
    256'h8880_0444_2022_1101_8808_4440_0222_1011_8088_4404_2220_0111_0888_4044_2202_1110;

  function automatic logic [63:0] rc(input logic [3:0] idx);
    case (idx)
      4'd1:    rc = 64'h13198a2e03707344;
      4'd2:    rc = 64'ha4093822299f31d0;
      4'd3:    rc = 64'h082efa98ec4e6c89;
      4'd4:    rc = 64'h452821e638d01377;
      4'd5:    rc = 64'hbe5466cf34e90c6c;
      4'd6:    rc = 64'h7ef84f78fd955cb1;
      4'd7:    rc = 64'h85840851f1ac43aa;
      4'd8:    rc = 64'hc882d32f25323c54;
      4'd9:    rc = 64'h64a51195e0e3610d;
      4'd10:   rc = 64'hd3b5a399ca0c2399;
      4'd11:   rc = 64'hc0ac29b7c97c50dd;
      default: rc = 64'h0;
    endcase
  endfunction

  function automatic logic [63:0] sub_nib(input logic [63:0] x, input logic [63:0] tab);
    logic [63:0] r;
    for (int i = 0; i < 16; i++) r[i*4 +: 4] = tab[{x[i*4 +: 4], 2'b00} +: 4];
    return r;
  endfunction

  function automatic logic [15:0] mult16(input logic [15:0] x, input logic [255:0] mat);
    logic [15:0] r;
    r = '0;
    for (int i = 0; i < 16; i++) if (x[i]) r = r ^ mat[i*16 +: 16];
    return r;
  endfunction

  function automatic logic [63:0] m_prime(input logic [63:0] x);
    return {mult16(x[63:48], MatHat0), mult16(x[47:32], MatHat1),
            mult16(x[31:16], MatHat1), mult16(x[15:0], MatHat0)};
  endfunction

  // Nibble p lives in column 3 - p%4; column c rotates left by 4*c nibbles.
  function automatic logic [63:0] shift_rows(input logic [63:0] x, input logic inv);
    logic [63:0] r;
    int          dst;
    r = '0;
    for (int p = 0; p < 16; p++) begin
      dst = inv ? (p + 16 - 4 * (3 - p % 4)) % 16 : (p + 4 * (3 - p % 4)) % 16;
      r[dst*4 +: 4] = x[p*4 +: 4];
    end
    return r;
  endfunction

  function automatic logic [63:0] apply_slot(input logic [63:0] st, input logic [3:0] s,
                                             input logic [63:0] wki, input logic [63:0] wko,
                                             input logic [63:0] rk);
    logic [63:0] r;
    if (s == 4'd0) begin
      r = st ^ wki ^ rk ^ rc(4'd0);
    end else if (s <= 4'd5) begin
      r = shift_rows(m_prime(sub_nib(st, Sbox)), 1'b0) ^ rk ^ rc(s);
    end else if (s == 4'd6) begin
      r = sub_nib(m_prime(sub_nib(st, Sbox)), SboxInv);
    end else if (s <= 4'd10) begin
      r = sub_nib(m_prime(shift_rows(st ^ rk ^ rc(s - 4'd1), 1'b1)), SboxInv);
    end else begin
      r = sub_nib(m_prime(shift_rows(st ^ rk ^ rc(4'd10), 1'b1)), SboxInv) ^ rk ^ rc(4'd11) ^ wko;
    end
    return r;
  endfunction

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e      state_q, state_d;
  logic [3:0]  slot_q, slot_d;
  logic [63:0] st_q, st_d;
  logic [63:0] wk_in_q, wk_in_d, wk_out_q, wk_out_d, rk_q, rk_d;
  logic        out_valid_q, out_valid_d;
  logic [63:0] data_out_q, data_out_d;
  logic        accept;
  logic [63:0] k0, k1, k0_prime;
  logic [63:0] chain [UNROLL+1];

  assign k0       = key[127:64];
  assign k1       = key[63:0];
  assign k0_prime = {k0[0], k0[63:1]} ^ {63'b0, k0[63]};

  assign chain[0] = st_q;
  for (genvar u = 0; u < UNROLL; u++) begin : gen_slot
    assign chain[u+1] = apply_slot(chain[u], slot_q + 4'(u), wk_in_q, wk_out_q, rk_q);
  end

  always_comb begin
    state_d     = state_q;
    slot_d      = slot_q;
    st_d        = st_q;
    wk_in_d     = wk_in_q;
    wk_out_d    = wk_out_q;
    rk_d        = rk_q;
    out_valid_d = out_valid_q;
    data_out_d  = data_out_q;
    in_ready    = 1'b0;
    case (state_q)
      StIdle: in_ready = 1'b1;
      StRun: begin
        st_d   = chain[UNROLL];
        slot_d = slot_q + Step;
        if (slot_q + Step == 4'd12) begin
          data_out_d  = chain[UNROLL];
          out_valid_d = 1'b1;
          state_d     = StDone;
        end
      end
      StDone: begin
        in_ready = out_ready;
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    accept = in_valid & in_ready;
    // An accept in DONE overrides the return to IDLE.
    if (accept) begin
      state_d  = StRun;
      slot_d   = 4'd0;
      st_d     = data_in;
      wk_in_d  = mode ? k0_prime : k0;
      wk_out_d = mode ? k0 : k0_prime;
      rk_d     = mode ? (k1 ^ Alpha) : k1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      slot_q      <= 4'd0;
      st_q        <= '0;
      wk_in_q     <= '0;
      wk_out_q    <= '0;
      rk_q        <= '0;
      out_valid_q <= 1'b0;
      data_out_q  <= '0;
    end else begin
      state_q     <= state_d;
      slot_q      <= slot_d;
      st_q        <= st_d;
      wk_in_q     <= wk_in_d;
      wk_out_q    <= wk_out_d;
      rk_q        <= rk_d;
      out_valid_q <= out_valid_d;
      data_out_q  <= data_out_d;
    end
  end

  assign out_valid = out_valid_q;
  assign data_out  = data_out_q;

endmodule

// File: tb/tb_prince_iter_engine.sv
module tb_prince_iter_engine;

  localparam int unsigned DutUnroll = 1;
  localparam int          Period    = 1 + 12 / DutUnroll;
  localparam int          NLat      = 6;

  logic         clk, rst;
  logic         in_valid, in_ready, mode, out_valid, out_ready;
  logic [63:0]  data_in, data_out;
  logic [127:0] key;

  logic              lat_valid, lat_mode, lat_ready;
  logic [63:0]       lat_data;
  logic [127:0]      lat_key;
  logic [NLat-1:0]   lat_ir, lat_ov;
  logic [63:0]       lat_do [NLat];

  int checks = 0;
  int failures = 0;

  function automatic int unsigned lu(input int g);
    case (g)
      0: return 1;
      1: return 2;
      2: return 3;
      3: return 4;
      4: return 6;
      default: return 12;
    endcase
  endfunction

  prince_iter_engine #(.UNROLL(DutUnroll)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .mode(mode),
    .data_in(data_in), .key(key), .out_valid(out_valid), .out_ready(out_ready),
    .data_out(data_out)
  );

  for (genvar g = 0; g < NLat; g++) begin : g_lat
    prince_iter_engine #(.UNROLL(lu(g))) u_lat (
      .clk(clk), .rst(rst), .in_valid(lat_valid), .in_ready(lat_ir[g]), .mode(lat_mode),
      .data_in(lat_data), .key(lat_key), .out_valid(lat_ov[g]), .out_ready(lat_ready),
      .data_out(lat_do[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- behavioural reference model ----------------
  function automatic logic [3:0] sb(input logic [3:0] x);
    case (x)
      4'h0: sb = 4'hb;  4'h1: sb = 4'hf;  4'h2: sb = 4'h3;  4'h3: sb = 4'h2;
      4'h4: sb = 4'ha;  4'h5: sb = 4'hc;  4'h6: sb = 4'h9;  4'h7: sb = 4'h1;
      4'h8: sb = 4'h6;  4'h9: sb = 4'h7;  4'ha: sb = 4'h8;  4'hb: sb = 4'h0;
      4'hc: sb = 4'he;  4'hd: sb = 4'h5;  4'he: sb = 4'hd;  default: sb = 4'h4;
    endcase
  endfunction

  function automatic logic [3:0] sbi(input logic [3:0] y);
    logic [3:0] r;
    r = 4'h0;
    for (int v = 0; v < 16; v++) if (sb(4'(v)) == y) r = 4'(v);
    return r;
  endfunction

  function automatic logic [63:0] rc_ref(input int i);
    case (i)
      1: return 64'h13198a2e03707344;   2: return 64'ha4093822299f31d0;
      3: return 64'h082efa98ec4e6c89;   4: return 64'h452821e638d01377;
      5: return 64'hbe5466cf34e90c6c;   6: return 64'h7ef84f78fd955cb1;
      7: return 64'h85840851f1ac43aa;   8: return 64'hc882d32f25323c54;
      9: return 64'h64a51195e0e3610d;   10: return 64'hd3b5a399ca0c2399;
      11: return 64'hc0ac29b7c97c50dd;  default: return 64'h0;
    endcase
  endfunction

  function automatic logic [63:0] sl(input logic [63:0] x, input bit inv);
    logic [63:0] y;
    for (int j = 0; j < 16; j++) y[4*j +: 4] = inv ? sbi(x[4*j +: 4]) : sb(x[4*j +: 4]);
    return y;
  endfunction

  // Block matrices written MSB-first: out nibble r, bit b drops input nibble c when (r+c+k)%4==b.
  function automatic logic [63:0] mp_ref(input logic [63:0] x);
    logic [63:0] y;
    logic        acc;
    int          k;
    y = '0;
    for (int blk = 0; blk < 4; blk++) begin
      k = (blk == 1 || blk == 2) ? 1 : 0;
      for (int r = 0; r < 4; r++) begin
        for (int bb = 0; bb < 4; bb++) begin
          acc = 1'b0;
          for (int c = 0; c < 4; c++)
            if ((r + c + k) % 4 != bb) acc = acc ^ x[63 - (blk * 16 + c * 4 + bb)];
          y[63 - (blk * 16 + r * 4 + bb)] = acc;
        end
      end
    end
    return y;
  endfunction

  function automatic int srp(input int j);
    case (j)
      0: return 0;   1: return 5;   2: return 10;  3: return 15;
      4: return 4;   5: return 9;   6: return 14;  7: return 3;
      8: return 8;   9: return 13;  10: return 2;  11: return 7;
      12: return 12; 13: return 1;  14: return 6;  default: return 11;
    endcase
  endfunction

  function automatic logic [63:0] sr_ref(input logic [63:0] x, input bit inv);
    logic [63:0] y;
    for (int j = 0; j < 16; j++) begin
      if (!inv) y[63 - 4*j -: 4] = x[63 - 4*srp(j) -: 4];
      else      y[63 - 4*srp(j) -: 4] = x[63 - 4*j -: 4];
    end
    return y;
  endfunction

  function automatic logic [63:0] m_ref(input logic [63:0] x);
    return sr_ref(mp_ref(x), 1'b0);
  endfunction

  function automatic logic [63:0] mi_ref(input logic [63:0] x);
    return mp_ref(sr_ref(x, 1'b1));
  endfunction

  // Decryption is modelled as the literal inverse of the encryption rounds.
  function automatic logic [63:0] prince_ref(input logic md, input logic [63:0] d,
                                             input logic [127:0] k);
    logic [63:0] k0, k1, k0p, s;
    k0  = k[127:64];
    k1  = k[63:0];
    k0p = {k0[0], k0[63:1]} ^ (k0 >> 63);
    if (!md) begin
      s = d ^ k0 ^ k1 ^ rc_ref(0);
      for (int i = 1; i <= 5; i++) s = m_ref(sl(s, 0)) ^ k1 ^ rc_ref(i);
      s = sl(mp_ref(sl(s, 0)), 1);
      for (int i = 6; i <= 10; i++) s = sl(mi_ref(s ^ k1 ^ rc_ref(i)), 1);
      s = s ^ k1 ^ rc_ref(11) ^ k0p;
    end else begin
      s = d ^ k0p ^ k1 ^ rc_ref(11);
      for (int i = 10; i >= 6; i--) s = m_ref(sl(s, 0)) ^ k1 ^ rc_ref(i);
      s = sl(mp_ref(sl(s, 0)), 1);
      for (int i = 5; i >= 1; i--) s = sl(mi_ref(s ^ k1 ^ rc_ref(i)), 1);
      s = s ^ k0 ^ k1 ^ rc_ref(0);
    end
    return s;
  endfunction

  // ---------------- checking helpers ----------------
  task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%b required=%b", name, act, exp);
    end
  endtask

  function automatic logic [63:0] r64();
    return {$urandom, $urandom};
  endfunction

  // One request with out_ready=1; returns result, latency in cycles, and whether it arrived.
  task automatic run_one(input logic md, input logic [63:0] din, input logic [127:0] k,
                         output logic [63:0] res, output int lat, output logic ok);
    @(negedge clk);
    mode = md; data_in = din; key = k; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    // Disturb inputs after accept; the engine must ignore them.
    in_valid = 1'b0; mode = 1'($urandom); data_in = r64(); key = {r64(), r64()};
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    res = data_out;
    ok  = out_valid;
  endtask

  typedef struct packed {
    logic         md;
    logic [127:0] k;
    logic [63:0]  d;
    logic [63:0]  e;
  } vec_t;

  vec_t        vecs [5];
  logic [63:0] res, res2, held, pd, kd;
  logic [127:0] rk;
  logic        ok;
  int          lat, bad, xfers;
  int          lat_seen [NLat];
  logic [63:0] lat_res [NLat];
  logic        rq_m [4];
  logic [63:0] rq_d [4];
  logic [127:0] rq_k [4];
  logic [63:0] out_d [4];
  int          out_c [4], acc_c [4];
  int          idx, nres;

  initial begin
    vecs[0] = '{md: 1'b0, k: 128'h0, d: 64'h0, e: 64'h818665aa0d02dfda};
    vecs[1] = '{md: 1'b0, k: 128'h0, d: 64'hffffffffffffffff, e: 64'h604ae6ca03c20ada};
    vecs[2] = '{md: 1'b0, k: {64'hffffffffffffffff, 64'h0}, d: 64'h0, e: 64'h9fb51935fc3df524};
    vecs[3] = '{md: 1'b0, k: {64'h0, 64'hfedcba9876543210}, d: 64'h0123456789abcdef,
                e: 64'hae25ad3ca8fa9ccf};
    vecs[4] = '{md: 1'b1, k: 128'h0, d: 64'h818665aa0d02dfda, e: 64'h0};

    rst = 1'b1; in_valid = 1'b0; mode = 1'b0; data_in = '0; key = '0; out_ready = 1'b0;
    lat_valid = 1'b0; lat_mode = 1'b0; lat_data = '0; lat_key = '0; lat_ready = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check1("reset_in_ready", in_ready, 1'b1);
    check1("reset_out_valid", out_valid, 1'b0);
    check64("reset_data_out", data_out, 64'h0);
    check_int("reset_lat_in_ready", int'(lat_ir), (1 << NLat) - 1);

    // Latency and zero vector for every legal UNROLL.
    @(negedge clk);
    lat_valid = 1'b1;
    for (int g = 0; g < NLat; g++) lat_seen[g] = 0;
    for (int cnt = 1; cnt <= 20; cnt++) begin
      @(negedge clk);
      lat_valid = 1'b0;
      #1;
      for (int g = 0; g < NLat; g++) begin
        if (lat_ov[g] && lat_seen[g] == 0) begin
          lat_seen[g] = cnt;
          lat_res[g]  = lat_do[g];
        end
      end
    end
    for (int g = 0; g < NLat; g++) begin
      check_int($sformatf("latency_unroll%0d", lu(g)), lat_seen[g], 1 + 12 / int'(lu(g)));
      check64($sformatf("zero_vec_unroll%0d", lu(g)), lat_res[g], 64'h818665aa0d02dfda);
    end

    // Known-answer table.
    for (int i = 0; i < 5; i++) begin
      run_one(vecs[i].md, vecs[i].d, vecs[i].k, res, lat, ok);
      check1($sformatf("kat%0d_valid", i), ok, 1'b1);
      check64($sformatf("kat%0d_data", i), res, vecs[i].e);
      check_int($sformatf("kat%0d_latency", i), lat, Period);
    end

    // Random encrypt/decrypt round trips.
    for (int i = 0; i < 100; i++) begin
      rk = {r64(), r64()};
      pd = r64();
      run_one(1'b0, pd, rk, res, lat, ok);
      check64($sformatf("rand%0d_enc", i), res, prince_ref(1'b0, pd, rk));
      run_one(1'b1, res, rk, res2, lat, ok);
      check64($sformatf("rand%0d_roundtrip", i), res2, pd);
      check64($sformatf("rand%0d_dec_model", i), prince_ref(1'b1, res, rk), pd);
    end

    // Backpressure: hold out_ready low 20 cycles, with a pending request at the input.
    rk = {r64(), r64()};
    pd = r64();
    @(negedge clk);
    mode = 1'b0; data_in = pd; key = rk; in_valid = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    data_in = r64(); key = {r64(), r64()};
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check_int("bp_latency", lat, Period);
    held = data_out;
    check64("bp_data", held, prince_ref(1'b0, pd, rk));
    bad = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      data_in = r64(); mode = 1'($urandom);
      #1;
      if (data_out !== held || in_ready !== 1'b0 || out_valid !== 1'b1) bad++;
    end
    check_int("bp_stall_cycles_bad", bad, 0);
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    #1;
    check1("bp_release_in_ready", in_ready, 1'b1);
    xfers = 0;
    for (int c = 0; c < 10; c++) begin
      if (out_valid && out_ready) xfers++;
      @(negedge clk);
      #1;
    end
    check_int("bp_transfers", xfers, 1);

    // Back-to-back: four queued requests, in_valid and out_ready held high.
    for (int i = 0; i < 4; i++) begin
      rq_m[i] = 1'($urandom); rq_d[i] = r64(); rq_k[i] = {r64(), r64()};
    end
    idx = 0; nres = 0;
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 200 && nres < 4; cyc++) begin
      @(negedge clk);
      if (idx < 4) begin
        in_valid = 1'b1; mode = rq_m[idx]; data_in = rq_d[idx]; key = rq_k[idx];
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (out_valid && out_ready) begin
        out_d[nres] = data_out; out_c[nres] = cyc; nres++;
      end
      if (in_valid && in_ready) begin
        acc_c[idx] = cyc; idx++;
      end
    end
    in_valid = 1'b0;
    check_int("b2b_results", nres, 4);
    if (nres == 4) begin
      for (int i = 0; i < 4; i++) begin
        check64($sformatf("b2b%0d_data", i), out_d[i], prince_ref(rq_m[i], rq_d[i], rq_k[i]));
        if (i > 0) begin
          check_int($sformatf("b2b%0d_spacing", i), out_c[i] - out_c[i-1], Period);
          check_int($sformatf("b2b%0d_accept_cycle", i), acc_c[i], out_c[i-1]);
        end
      end
    end

    // Reset during slot 5.
    @(negedge clk);
    mode = 1'b0; data_in = r64(); key = {r64(), r64()}; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check1("midrst_out_valid", out_valid, 1'b0);
    check1("midrst_in_ready", in_ready, 1'b1);
    check64("midrst_data_out", data_out, 64'h0);
    bad = 0;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      #1;
      if (out_valid !== 1'b0) bad++;
    end
    check_int("midrst_no_output", bad, 0);
    run_one(vecs[3].md, vecs[3].d, vecs[3].k, res, lat, ok);
    check64("midrst_fresh_data", res, vecs[3].e);
    check_int("midrst_fresh_latency", lat, Period);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
